even_parity_tx: RTL
===================

Name: even_parity_tx

Overview:
Serial transmitter that frames a DATA_W-bit word with an even-parity bit and shifts it out on a single line.
- Frame format: start, data LSB first, parity, stop.
- Transmit-side counterpart of the 4-bit even parity checker. A receiver that recovers data[3:0] and the parity bit and feeds them to that checker must see error=0 for every frame this block sends.
- Sits between a word-producing block (valid/ready handshake) and the serial link.

Parameters:
- DATA_W, 4: payload width in bits, ≥1. The default matches the checker's data width.
- CLKS_PER_BIT, 4: clock cycles each serial bit is held, ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  DATA_W  word to transmit; sampled only on acceptance.
- data_valid  in  1  producer has a word.
- data_ready  out  1  block can accept a word.
- tx_serial  out  1  serial line, idle high.
- tx_busy  out  1  frame in progress (any state other than IDLE).
- parity_out  out  1  even-parity bit of the last accepted word.
- tx_done  out  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset (async, active-high): the following take effect immediately while rst=1, including mid-frame with no partial bit completed.
  - state=IDLE
  - tx_serial=1, tx_busy=0, tx_done=0, parity_out=0
  - data_ready=0
  - bit and cycle counters=0
- data_ready = (state==IDLE) && !rst. It is 1 on the first cycle after rst deasserts.
- Acceptance: on a rising edge with data_valid && data_ready:
  - latch data_in into the shift register;
  - set parity_out = XOR-reduction of data_in, so that ones(data)+parity is even;
  - go to START.
  - data_in and data_valid are ignored in every other state.
- States (each held CLKS_PER_BIT cycles unless noted):
  - IDLE: tx_serial=1.
  - START: tx_serial=0.
  - DATA: tx_serial = data bit[i], i=0..DATA_W-1, LSB first. The bit counter increments every CLKS_PER_BIT cycles; after bit DATA_W-1, go to PARITY.
  - PARITY: tx_serial=parity_out.
  - STOP: tx_serial=1. On its last cycle, go to IDLE.
- tx_serial is registered. The start bit appears on the cycle after the acceptance edge.
- Frame length: from START entry to IDLE entry is exactly (DATA_W+3)*CLKS_PER_BIT cycles.
- tx_done is high for exactly the first IDLE cycle after STOP, concurrent with data_ready=1.
- Back-to-back: if data_valid is high in that IDLE cycle, the next word is accepted there. The line then stays high for CLKS_PER_BIT+1 cycles between frames (stop bit plus one idle cycle). No other gap is permitted.
- Counters: cycle counter is $clog2(CLKS_PER_BIT) bits, minimum 1. It wraps to 0 on every bit boundary; there is no free-running wrap.
- CLKS_PER_BIT=1 must work: one state per bit.
- Parity is computed from the latched word. Changes on data_in after acceptance do not affect tx_serial or parity_out.

Decomposition:
- Shared package even_parity_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP;
  - constants START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1;
  - a frame_len(DATA_W, CLKS_PER_BIT) function.
- One sub-module: even_parity_gen, a combinational XOR reduction over DATA_W bits giving the even-parity bit. It is reused by the TX and by any future wide checker.

Test Plan:
- Reset during PARITY state of a frame: assert rst → tx_serial=1, tx_busy=0 and data_ready=0 in the same cycle. After release, data_ready=1 and the next frame starts cleanly.
- Single frame, data_in=4'b1011, CLKS_PER_BIT=4:
  - tx_serial sequence, each bit held 4 cycles: 0 | 1,1,0,1 | 1 | 1;
  - parity_out=1;
  - tx_done pulses 28 cycles after the START state is entered.
- Parity boundaries: 4'b0000 → parity bit 0; 4'b1111 → parity 0; 4'b1000 → parity 1. Check each on the line during PARITY.
- Back-to-back: data_valid held high with words 4'h5 then 4'hA. The second is accepted on the tx_done cycle, and the line is high for exactly 5 cycles between the stop bit's start and the next start bit.
- Mid-frame disturbance: toggle data_in and data_valid while busy → serial output and parity_out are unchanged, data_ready stays 0.
- Loopback for all 16 values with CLKS_PER_BIT=1 and 3: a mid-bit sampling receiver feeds the recovered data and parity into the even parity checker → error=0 every frame. Forcing the sampled parity bit inverted → error=1.

Source files
------------

// File: rtl/even_parity_pkg.sv
// -----------------------------------------------------------------------------
// even_parity_pkg
// Shared definitions for the even-parity serial transmitter and its helpers.
//   state_t      : transmitter frame states
//   *_LEVEL      : line levels for start / stop / idle
//   frame_len()  : clock cycles from START entry to IDLE entry for one frame
// -----------------------------------------------------------------------------
package even_parity_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    // Start bit + DATA_W data bits + parity bit + stop bit, each held
    // clks_per_bit cycles.
    function automatic int frame_len(input int data_w, input int clks_per_bit);
        return (data_w + 3) * clks_per_bit;
    endfunction

endpackage

// File: rtl/even_parity_tx_if.sv
// -----------------------------------------------------------------------------
// even_parity_tx_if
// Valid/ready word handshake between a word producer and the transmitter.
//   data_in    : word to transmit (producer -> tx)
//   data_valid : producer has a word (producer -> tx)
//   data_ready : transmitter can accept a word (tx -> producer)
// Modports: master = producer side, slave = transmitter side.
// -----------------------------------------------------------------------------
interface even_parity_tx_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/even_parity_gen.sv
// -----------------------------------------------------------------------------
// even_parity_gen
// Combinational even-parity generator: parity is chosen so that the number of
// ones in {data, parity} is even.
//   data   : DATA_W-bit input word
//   parity : XOR reduction of data
// -----------------------------------------------------------------------------
module even_parity_gen #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] data,
    output logic              parity
);
    assign parity = ^data;
endmodule

// File: rtl/even_parity_tx.sv
// -----------------------------------------------------------------------------
// even_parity_tx
// Serial transmitter: accepts a DATA_W-bit word over a valid/ready handshake
// and sends start(0), data LSB first, even parity, stop(1), each bit held
// CLKS_PER_BIT cycles. Line idles high.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   bus        : word handshake (slave side)
//   tx_serial  : registered serial line
//   tx_busy    : a frame is in progress (state other than IDLE)
//   parity_out : even-parity bit of the last accepted word
//   tx_done    : one-cycle pulse in the first IDLE cycle after a stop bit
// -----------------------------------------------------------------------------
module even_parity_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    even_parity_tx_if.slave bus,
    output logic            tx_serial,
    output logic            tx_busy,
    output logic            parity_out,
    output logic            tx_done
);
    import even_parity_pkg::*;

    // Counters are at least one bit wide so CLKS_PER_BIT=1 / DATA_W=1 still build.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_q, par_d;
    logic              serial_d;
    logic              done_d;
    logic              bit_end;
    logic              accept;
    logic              par_in;

    assign bit_end        = (cyc_q == CYC_LAST);
    assign bus.data_ready = (state_q == IDLE) && !rst;
    assign accept         = bus.data_valid && bus.data_ready;
    assign tx_busy        = (state_q != IDLE);
    assign parity_out     = par_q;

    even_parity_gen #(
        .DATA_W (DATA_W)
    ) u_gen (
        .data   (bus.data_in),
        .parity (par_in)
    );

    // State register: control, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            bit_q     <= '0;
            par_q     <= 1'b0;
            tx_serial <= IDLE_LEVEL;
            tx_done   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            par_q     <= par_d;
            tx_serial <= serial_d;
            tx_done   <= done_d;
        end
    end

    // Payload shift register carries data only and needs no reset.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;

        // Cycle counter only runs inside a frame and clears on each bit boundary.
        if (state_q != IDLE) begin
            cyc_d = bit_end ? '0 : cyc_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    shreg_d = bus.data_in;
                    par_d   = par_in;
                    cyc_d   = '0;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = PARITY;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: the line level is computed from the upcoming state so the
    // registered line changes on the same edge as the state.
    always_comb begin
        serial_d = IDLE_LEVEL;
        done_d   = (state_q == STOP) && bit_end;
        case (state_d)
            IDLE:    serial_d = IDLE_LEVEL;
            START:   serial_d = START_LEVEL;
            DATA:    serial_d = shreg_d[0];
            PARITY:  serial_d = par_d;
            STOP:    serial_d = STOP_LEVEL;
            default: serial_d = IDLE_LEVEL;
        endcase
    end

endmodule
